// File: rtl/spi_sram_decoder.sv
// spi_sram_decoder: device end of a quad-I/O (SQI) serial SRAM link.
// Decodes EQIO/RSTIO mode commands and quad READ/WRITE transactions on SIO[3:0]
// and serves 16-bit words from an internal word array. sram_sck is oversampled
// on clk (same clock domain as the initiator, so no synchronizer).
// Optional feature: define SPI_SRAM_DECODER_SEQ_EN to let a transaction keep
// streaming consecutive words while chip select stays low.
module spi_sram_decoder #(
    parameter int WORD_WIDTH = 16,
    parameter int MEM_WORDS  = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sram_cs_n,
    input  logic       sram_sck,
    input  logic [3:0] sram_sio_i,
    output logic [3:0] sram_sio_o,
    output logic       sram_sio_oe,
    output logic       sqi_mode,
    output logic       transfer_done
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [AW-1:0] WORD_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE, SPI_CMD, INSTR, ADDR, DUMMY, RDATA, WDATA, IGNORE
    } state_t;

    state_t state, state_next;

    logic                  sck_q;
    logic                  rise;
    logic                  fall;
    logic [2:0]            cnt;
    logic [7:0]            cmd;
    logic [AW:0]           addr;
    logic [AW-1:0]         word;
    logic [WORD_WIDTH-1:0] wdata;
    logic [WORD_WIDTH-1:0] rd_sreg;
    logic                  is_read;
    logic [WORD_WIDTH-1:0] mem [MEM_WORDS];

    logic [7:0]            spi_byte;
    logic [7:0]            quad_byte;
    logic [AW:0]           addr_shifted;
    logic [WORD_WIDTH-1:0] wdata_full;
    logic [AW-1:0]         rd_word;

    logic cnt_clr, cnt_inc, cmd_ser, cmd_quad, addr_shift, word_latch;
    logic wdata_shift, mem_we, done_pulse, rd_load, rd_next, rd_adv;
    logic word_inc, oe_off, sqi_set, sqi_clr, read_set, write_set;

    assign rise         = sram_sck & ~sck_q;
    assign fall         = ~sram_sck & sck_q;
    assign spi_byte     = (cmd << 1) | {7'b0, sram_sio_i[0]};
    assign quad_byte    = (cmd << 4) | {4'b0, sram_sio_i};
    assign addr_shifted = (addr << 4) | {{(AW-3){1'b0}}, sram_sio_i};
    assign wdata_full   = (wdata << 4) | {{(WORD_WIDTH-4){1'b0}}, sram_sio_i};
    assign rd_word      = rd_next ? word + WORD_ONE : word;

    // Previous sram_sck level, used to find its rising and falling edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sck_q <= 1'b0;
        else          sck_q <= sram_sck;
    end

    // Transaction state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next state and datapath strobes; chip select high aborts everything
    always_comb begin
        state_next  = state;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        cmd_ser     = 1'b0;
        cmd_quad    = 1'b0;
        addr_shift  = 1'b0;
        word_latch  = 1'b0;
        wdata_shift = 1'b0;
        mem_we      = 1'b0;
        done_pulse  = 1'b0;
        rd_load     = 1'b0;
        rd_next     = 1'b0;
        rd_adv      = 1'b0;
        word_inc    = 1'b0;
        oe_off      = 1'b0;
        sqi_set     = 1'b0;
        sqi_clr     = 1'b0;
        read_set    = 1'b0;
        write_set   = 1'b0;
        if (sram_cs_n) begin
            state_next = IDLE;
            cnt_clr    = 1'b1;
            oe_off     = 1'b1;
        end else begin
            case (state)
                IDLE: if (rise) begin
                    cnt_inc = 1'b1;
                    if (sqi_mode) begin
                        cmd_quad   = 1'b1;
                        state_next = INSTR;
                    end else begin
                        cmd_ser    = 1'b1;
                        state_next = SPI_CMD;
                    end
                end
                SPI_CMD: if (rise) begin
                    if (cnt == 3'd7) begin
                        cnt_clr    = 1'b1;
                        state_next = IGNORE;
                        if (spi_byte == 8'h38) sqi_set = 1'b1;
                    end else begin
                        cmd_ser = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
                INSTR: if (rise) begin
                    if (cnt == 3'd1) begin
                        cnt_clr = 1'b1;
                        case (quad_byte)
                            8'h03: begin
                                read_set   = 1'b1;
                                state_next = ADDR;
                            end
                            8'h02: begin
                                write_set  = 1'b1;
                                state_next = ADDR;
                            end
                            8'hFF: begin
                                sqi_clr    = 1'b1;
                                state_next = IGNORE;
                            end
                            default: state_next = IGNORE;
                        endcase
                    end else begin
                        cmd_quad = 1'b1;
                        cnt_inc  = 1'b1;
                    end
                end
                ADDR: if (rise) begin
                    addr_shift = 1'b1;
                    if (cnt == 3'd5) begin
                        word_latch = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = is_read ? DUMMY : WDATA;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                DUMMY: begin
                    if (rise && cnt < 3'd2) begin
                        cnt_inc = 1'b1;
                    end else if (fall && cnt == 3'd2) begin
                        rd_load    = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = RDATA;
                    end
                end
                RDATA: begin
                    if (rise && cnt < 3'd4) begin
                        cnt_inc = 1'b1;
                        if (cnt == 3'd3) done_pulse = 1'b1;
                    end else if (fall) begin
                        if (cnt == 3'd4) begin
`ifdef SPI_SRAM_DECODER_SEQ_EN
                            rd_load  = 1'b1;
                            rd_next  = 1'b1;
                            word_inc = 1'b1;
                            cnt_clr  = 1'b1;
`else
                            oe_off     = 1'b1;
                            state_next = IGNORE;
`endif
                        end else begin
                            rd_adv = 1'b1;
                        end
                    end
                end
                WDATA: if (rise) begin
                    wdata_shift = 1'b1;
                    if (cnt == 3'd3) begin
                        mem_we     = 1'b1;
                        done_pulse = 1'b1;
`ifdef SPI_SRAM_DECODER_SEQ_EN
                        word_inc = 1'b1;
                        cnt_clr  = 1'b1;
`else
                        state_next = IGNORE;
`endif
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Counters, shift registers, mode flag and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt           <= '0;
            cmd           <= '0;
            addr          <= '0;
            word          <= '0;
            wdata         <= '0;
            rd_sreg       <= '0;
            is_read       <= 1'b0;
            sqi_mode      <= 1'b0;
            sram_sio_oe   <= 1'b0;
            sram_sio_o    <= '0;
            transfer_done <= 1'b0;
        end else begin
            transfer_done <= done_pulse;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 3'd1;
            if (cmd_ser)       cmd <= spi_byte;
            else if (cmd_quad) cmd <= quad_byte;
            if (addr_shift) addr <= addr_shifted;
            if (word_latch)    word <= AW'(addr_shifted >> 1);
            else if (word_inc) word <= word + WORD_ONE;
            if (wdata_shift) wdata <= wdata_full;
            if (read_set)       is_read <= 1'b1;
            else if (write_set) is_read <= 1'b0;
            if (sqi_set)      sqi_mode <= 1'b1;
            else if (sqi_clr) sqi_mode <= 1'b0;
            if (oe_off) begin
                sram_sio_oe <= 1'b0;
                sram_sio_o  <= '0;
            end else if (rd_load) begin
                rd_sreg     <= mem[rd_word];
                sram_sio_o  <= mem[rd_word][WORD_WIDTH-1 -: 4];
                sram_sio_oe <= 1'b1;
            end else if (rd_adv) begin
                rd_sreg    <= rd_sreg << 4;
                sram_sio_o <= rd_sreg[WORD_WIDTH-5 -: 4];
            end
        end
    end

    // Word array write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[word] <= wdata_full;
    end

endmodule
